// File: rtl/ds_skid_buffer.sv
// ds_skid_buffer
//
// Two-entry skid buffer for the DataStream valid/ready interface. Both
// directions are registered: o_dat/o_val come from the output register, and
// i_rdy comes straight from the skid-valid flop, so there is no
// combinational path from o_rdy to i_rdy. Throughput is one word per clock,
// and latency is one cycle.
//
// Optional feature (macro DS_SKID_BUFFER_STAT_EN):
//   Adds the stall_cnt port. This saturating counter counts the clock edges
//   on which o_val=1 and o_rdy=0. When the macro is undefined, neither the
//   port nor the counter exists. The data path is the same in both builds.
//
// Ports:
//   clk        in   clock
//   reset_n    in   asynchronous active-low reset
//   i_dat      in   [WIDTH]       input data
//   i_val      in                 input valid
//   i_rdy      out                input ready (registered, = ~skd_val)
//   o_dat      out  [WIDTH]       output data (registered)
//   o_val      out                output valid (registered)
//   o_rdy      in                 output ready
//   stall_cnt  out  [STAT_WIDTH]  stall counter (DS_SKID_BUFFER_STAT_EN only)
//
// State is the pair {out_val, skd_val}:
//   state | meaning
//   ------+-------------------------------------------------------------
//   EMPTY | 00: nothing held. A valid input loads the output register.
//   HALF  | 10: one word in the output register; skid register is free.
//   FULL  | 11: output word stalled plus one overflow word; i_rdy=0.
//   (01)  | unreachable; decoded as a recovery back to EMPTY.

module ds_skid_buffer #(
    parameter int WIDTH      = 8,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [WIDTH-1:0]      i_dat,
    input  logic                  i_val,
    output logic                  i_rdy,
    output logic [WIDTH-1:0]      o_dat,
    output logic                  o_val,
    input  logic                  o_rdy
`ifdef DS_SKID_BUFFER_STAT_EN
    ,
    output logic [STAT_WIDTH-1:0] stall_cnt
`endif
);

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_HALF  = 2'b10;
    localparam logic [1:0] ST_FULL  = 2'b11;

    logic [WIDTH-1:0] out_dat_q, out_dat_d;
    logic             out_val_q, out_val_d;
    logic [WIDTH-1:0] skd_dat_q, skd_dat_d;
    logic             skd_val_q, skd_val_d;
    logic [1:0]       state;

    assign state = {out_val_q, skd_val_q};

    always_comb begin
        out_dat_d = out_dat_q;
        out_val_d = out_val_q;
        skd_dat_d = skd_dat_q;
        skd_val_d = skd_val_q;
        case (state)
            ST_EMPTY: begin
                if (i_val) begin
                    out_dat_d = i_dat;
                    out_val_d = 1'b1;
                end
            end
            ST_HALF: begin
                if (i_val && o_rdy) begin
                    // streaming: replace the departing word, no bubble
                    out_dat_d = i_dat;
                end else if (i_val && !o_rdy) begin
                    // i_rdy was already 1 this cycle, so park the word
                    skd_dat_d = i_dat;
                    skd_val_d = 1'b1;
                end else if (!i_val && o_rdy) begin
                    out_val_d = 1'b0;
                end
            end
            ST_FULL: begin
                // input side is closed here; i_val/i_dat are ignored
                if (o_rdy) begin
                    out_dat_d = skd_dat_q;
                    skd_val_d = 1'b0;
                end
            end
            default: begin
                out_val_d = 1'b0;
                skd_val_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_dat_q <= '0;
            out_val_q <= 1'b0;
            skd_dat_q <= '0;
            skd_val_q <= 1'b0;
        end else begin
            out_dat_q <= out_dat_d;
            out_val_q <= out_val_d;
            skd_dat_q <= skd_dat_d;
            skd_val_q <= skd_val_d;
        end
    end

    assign o_dat = out_dat_q;
    assign o_val = out_val_q;
    assign i_rdy = ~skd_val_q;

`ifdef DS_SKID_BUFFER_STAT_EN
    logic [STAT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        // saturate at all-ones, never wrap
        if (out_val_q && !o_rdy && (stall_cnt_q != {STAT_WIDTH{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STAT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
